// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared direction encodings and digit-width helper for the modulo counter
package mod_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic int clog2_safe(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/mod_counter_digit.sv
// mod_counter_digit: one modulo digit with clear, clamped load and up/down advance
module mod_counter_digit
  import mod_counter_pkg::*;
#(
  parameter int MODULUS = 10,
  localparam int W = clog2_safe(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         adv_i,
  input  logic         up_dn_i,
  output logic [W-1:0] q_o,
  output logic         is_term_o,
  output logic         ld_bad_o
);
  localparam logic [W-1:0] MAX = W'(MODULUS - 1);
  logic [W-1:0] q_q, q_d;
  assign q_o       = q_q;
  assign ld_bad_o  = ld_val_i > MAX;
  assign is_term_o = (up_dn_i == DIR_UP) ? (q_q == MAX) : (q_q == '0);
  // next digit value: clear, then clamped load, then wrap-around advance
  always_comb begin
    q_d = clr_i    ? '0 :
          ld_i     ? (ld_bad_o ? MAX : ld_val_i) :
          !adv_i   ? q_q :
          (up_dn_i == DIR_UP) ? ((q_q == MAX) ? '0 : q_q + W'(1)) :
                                ((q_q == '0) ? MAX : q_q - W'(1));
  end
  // digit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end
  a_in_range: assert property (@(posedge clk) disable iff (rst) q_q <= MAX);
endmodule

// File: rtl/mod_counter_cascade.sv
// mod_counter_cascade: multi-digit modulo up/down counter with load, clear, saturate and carry chaining
module mod_counter_cascade
  import mod_counter_pkg::*;
#(
  parameter int MODULUS  = 10,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0,
  localparam int W = clog2_safe(MODULUS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cin,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [DIGITS*W-1:0]   ld_val,
  output logic [DIGITS*W-1:0]   cnt,
  output logic                  cout,
  output logic                  tc,
  output logic                  ld_err,
  output logic                  ovf
);
  logic              step, limit, hold;
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] term, bad;
  logic              tc_q, tc_d, ld_err_q, ld_err_d, ovf_q, ovf_d;
  assign step     = en & cin & ~clr & ~ld;
  assign chain[0] = 1'b1;
  assign limit    = step & chain[DIGITS];
  assign hold     = limit & (SATURATE != 0);
  assign cout     = limit & (SATURATE == 0);
  assign tc       = tc_q;
  assign ld_err   = ld_err_q;
  assign ovf      = ovf_q;
  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_dig
    assign chain[g+1] = chain[g] & term[g];
    mod_counter_digit #(.MODULUS(MODULUS)) u_dig (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr),
      .ld_i     (ld),
      .ld_val_i (ld_val[g*W +: W]),
      .adv_i    (step & chain[g] & ~hold),
      .up_dn_i  (up_dn),
      .q_o      (cnt[g*W +: W]),
      .is_term_o(term[g]),
      .ld_bad_o (bad[g])
    );
  end
  // flag next state: limit pulse, bad-load pulse, sticky overflow cleared by clr
  always_comb begin
    tc_d     = limit;
    ld_err_d = ~clr & ld & |bad;
    ovf_d    = ~clr & (ovf_q | limit);
  end
  // flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_q     <= 1'b0;
      ld_err_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      tc_q     <= tc_d;
      ld_err_q <= ld_err_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
